// File: rtl/acia_pkg.sv
//==============================================================================
// Module      : acia_pkg
// Description : Shared constants and FSM state type for the ACIA bus master.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package acia_pkg;

    localparam int STAT_RDRF = 0;
    localparam int STAT_TDRE = 1;
    localparam int STAT_DCD  = 2;
    localparam int STAT_CTS  = 3;
    localparam int STAT_IRQ  = 7;

    localparam logic [7:0] CTRL_MASTER_RESET = 8'h03;

    localparam logic RS_CTRL = 1'b0;
    localparam logic RS_DATA = 1'b1;

    typedef enum logic [2:0] {
        ST_MRST  = 3'd0,
        ST_CFG   = 3'd1,
        ST_IDLE  = 3'd2,
        ST_POLL  = 3'd3,
        ST_CHECK = 3'd4,
        ST_WRITE = 3'd5,
        ST_GAP   = 3'd6,
        ST_RXRD  = 3'd7
    } acia_state_t;

endpackage

`default_nettype wire

// File: rtl/acia_byte_fifo.sv
//==============================================================================
// Module      : acia_byte_fifo
// Description : Synchronous byte FIFO, power-of-two depth, with occupancy.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module acia_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage carries no reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rptr_q];
    assign level = level_q;

endmodule

`default_nettype wire

// File: rtl/acia_tx_master.sv
//==============================================================================
// Module      : acia_tx_master
// Description : Initialises a 6850 ACIA and drains a byte FIFO into its TX
//               register, polling TDRE before each write. Optional receive
//               servicing is built when ACIA_RX_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module acia_tx_master
    import acia_pkg::*;
#(
    parameter int         FIFO_DEPTH    = 16,
    parameter logic [7:0] CTRL_WORD     = 8'h15,
    parameter int         GAP_POLLS     = 0,
    parameter int         TIMEOUT_POLLS = 65535
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bus_en,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          acia_cs,
    output logic                          acia_rw_n,
    output logic                          acia_rs,
    output logic [7:0]                    acia_wdata,
    input  logic [7:0]                    acia_rdata,
    output logic                          busy,
    output logic                          timeout_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_POLLS);
    localparam logic [15:0] GAP_LAST     = (GAP_POLLS > 0) ? 16'(GAP_POLLS - 1) : 16'd0;

    acia_state_t state_q, state_d;
    logic        cs_q, cs_d, rw_n_q, rw_n_d, rs_q, rs_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic        timeout_q, timeout_d;
    logic        rdy_en_q;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        unused_rdata_bits;

    assign in_ready  = rdy_en_q && !fifo_full;
    assign fifo_push = in_valid && in_ready;

    acia_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (in_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

`ifdef ACIA_RX_EN
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
`endif

    always_comb begin
        state_d    = state_q;
        cs_d       = cs_q;
        rw_n_d     = rw_n_q;
        rs_d       = rs_q;
        wdata_d    = wdata_q;
        poll_cnt_d = poll_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        timeout_d  = timeout_q;
        fifo_pop   = 1'b0;
`ifdef ACIA_RX_EN
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
`endif
        if (bus_en) begin
            // Each strobe presents the cycle for the current state; idle otherwise.
            cs_d   = 1'b0;
            rw_n_d = 1'b1;
            rs_d   = RS_CTRL;
            case (state_q)
                ST_MRST: begin
                    cs_d    = 1'b1;
                    rw_n_d  = 1'b0;
                    wdata_d = CTRL_MASTER_RESET;
                    state_d = ST_CFG;
                end
                ST_CFG: begin
                    cs_d    = 1'b1;
                    rw_n_d  = 1'b0;
                    wdata_d = CTRL_WORD;
                    state_d = ST_IDLE;
                end
                ST_IDLE: begin
`ifdef ACIA_RX_EN
                    state_d = ST_POLL;
`else
                    if (!fifo_empty) begin
                        state_d = ST_POLL;
                    end
`endif
                end
                ST_POLL: begin
                    cs_d    = 1'b1;
                    state_d = ST_CHECK;
                end
                ST_CHECK: begin
`ifdef ACIA_RX_EN
                    if (acia_rdata[STAT_RDRF]) begin
                        cs_d    = 1'b1;
                        rs_d    = RS_DATA;
                        state_d = ST_RXRD;
                    end else if (fifo_empty) begin
                        poll_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else
`endif
                    // poll_cnt holds the failed status reads seen so far.
                    if (acia_rdata[STAT_TDRE]) begin
                        poll_cnt_d = '0;
                        state_d    = ST_WRITE;
                    end else if (poll_cnt_q == TIMEOUT_LAST) begin
                        poll_cnt_d = '0;
                        timeout_d  = 1'b1;
                        state_d    = ST_MRST;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 16'd1;
                        state_d    = ST_POLL;
                    end
                end
                ST_WRITE: begin
                    cs_d      = 1'b1;
                    rw_n_d    = 1'b0;
                    rs_d      = RS_DATA;
                    wdata_d   = fifo_rdata;
                    fifo_pop  = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = (GAP_POLLS > 0) ? ST_GAP : ST_IDLE;
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 16'd1;
                    end
                end
                ST_RXRD: begin
`ifdef ACIA_RX_EN
                    rx_data_d  = acia_rdata;
                    rx_valid_d = 1'b1;
`endif
                    state_d = ST_POLL;
                end
                default: state_d = ST_MRST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_MRST;
            cs_q       <= 1'b0;
            rw_n_q     <= 1'b1;
            rs_q       <= RS_CTRL;
            wdata_q    <= 8'h00;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            timeout_q  <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            rw_n_q     <= rw_n_d;
            rs_q       <= rs_d;
            wdata_q    <= wdata_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            timeout_q  <= timeout_d;
            rdy_en_q   <= 1'b1;
        end
    end

`ifdef ACIA_RX_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`else
    assign rx_data  = 8'h00;
    assign rx_valid = 1'b0;
`endif

    // Status bits this master never acts on.
    assign unused_rdata_bits = ^{acia_rdata[STAT_IRQ], acia_rdata[6:4], acia_rdata[STAT_CTS],
                                 acia_rdata[STAT_DCD], acia_rdata[STAT_RDRF]};

    assign acia_cs     = cs_q;
    assign acia_rw_n   = rw_n_q;
    assign acia_rs     = rs_q;
    assign acia_wdata  = wdata_q;
    assign timeout_err = timeout_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_acia_tx_master.sv
//==============================================================================
// Module      : tb_acia_tx_master
// Description : Self-checking bench for acia_tx_master (default build).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_acia_tx_master;

    localparam int         D   = 16;
    localparam logic [7:0] CW  = 8'h15;
    localparam int         GAP = 1;
    localparam int         TMO = 6;

    logic       clk = 1'b0, reset = 1'b1, bus_en = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00, acia_rdata = 8'h02;
    logic       in_ready, acia_cs, acia_rw_n, acia_rs, busy, timeout_err, rx_valid;
    logic [7:0] acia_wdata, rx_data;
    logic [$clog2(D):0] fifo_level;

    always #5 clk = ~clk;

    acia_tx_master #(
        .FIFO_DEPTH    (D),
        .CTRL_WORD     (CW),
        .GAP_POLLS     (GAP),
        .TIMEOUT_POLLS (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_en      (bus_en),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .acia_cs     (acia_cs),
        .acia_rw_n   (acia_rw_n),
        .acia_rs     (acia_rs),
        .acia_wdata  (acia_wdata),
        .acia_rdata  (acia_rdata),
        .busy        (busy),
        .timeout_err (timeout_err),
        .fifo_level  (fifo_level),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference model: a script of the bus cycles still owed, plus a byte queue.
    typedef enum int {E_NONE, E_RD, E_CHK, E_W03, E_WCW, E_WDAT} ev_t;
    ev_t        exp_q[$];
    logic [7:0] bq[$];
    int         fails = 0;
    bit         m_tmo = 0, m_rdy_en = 0;
    bit         ecs = 0, erw = 1, ers = 0;
    logic [7:0] ewd = 8'h00;

    logic [7:0] dlog[$];
    logic [7:0] clog[$];
    int         dclk[$];
    int         rd_cnt = 0;
    int         clkno  = 0;

    always @(posedge clk) begin
        bit         s_rst, s_be, s_push, pop;
        logic [7:0] s_rd, s_in;
        ev_t        e;
        clkno++;
        s_rst  = reset;
        s_be   = bus_en;
        s_rd   = acia_rdata;
        s_in   = in_data;
        s_push = in_valid && m_rdy_en && (bq.size() < D);
        pop    = 0;
        if (s_rst) begin
            exp_q = {E_W03, E_WCW};
            bq.delete();
            fails = 0; m_tmo = 0; m_rdy_en = 0;
            ecs = 0; erw = 1; ers = 0;
        end else begin
            if (s_be) begin
                if (exp_q.size() == 0) begin
                    e = E_NONE;
                    if (bq.size() > 0) exp_q = {E_RD, E_CHK};
                end else begin
                    e = exp_q.pop_front();
                end
                ecs = 0; erw = 1; ers = 0;
                case (e)
                    E_RD:  ecs = 1;
                    E_CHK: begin
                        if (s_rd[1]) begin
                            fails = 0;
                            exp_q.push_back(E_WDAT);
                            repeat (GAP) exp_q.push_back(E_NONE);
                        end else begin
                            fails++;
                            if (fails > TMO) begin
                                m_tmo = 1; fails = 0;
                                exp_q = {E_W03, E_WCW};
                            end else begin
                                exp_q = {E_RD, E_CHK};
                            end
                        end
                    end
                    E_W03:  begin ecs = 1; erw = 0; ewd = 8'h03; end
                    E_WCW:  begin ecs = 1; erw = 0; ewd = CW; end
                    E_WDAT: begin ecs = 1; erw = 0; ers = 1; ewd = bq[0]; pop = 1; end
                    default: ;
                endcase
            end
            if (s_push) bq.push_back(s_in);
            if (pop) void'(bq.pop_front());
            m_rdy_en = 1;
        end
        #1;
        chk("cs", acia_cs, ecs);
        if (ecs) begin
            chk("rw_n", acia_rw_n, erw);
            chk("rs", acia_rs, ers);
            if (!erw) chk("wdata", acia_wdata, ewd);
        end
        chk("level", fifo_level, bq.size());
        chk("in_ready", in_ready, m_rdy_en && (bq.size() < D));
        chk("busy", busy, (exp_q.size() != 0) || (bq.size() != 0));
        chk("timeout", timeout_err, m_tmo);
`ifndef ACIA_RX_EN
        chk("rx_tied", {rx_valid, rx_data}, 9'h000);
`endif
        if (s_be && !s_rst && acia_cs) begin
            if (acia_rw_n) rd_cnt++;
            else if (acia_rs) begin dlog.push_back(acia_wdata); dclk.push_back(clkno); end
            else clog.push_back(acia_wdata);
        end
    end

    // ACIA status model: 0 ready, 1 scripted busy count, 2 stuck busy, 3 random.
    int rd_mode = 0, zero_n = 0, rd_base = 0;
    always @(negedge clk) begin
        case (rd_mode)
            0: acia_rdata = 8'h02;
            1: acia_rdata = ((rd_cnt - rd_base) <= zero_n) ? 8'h00 : 8'h02;
            2: acia_rdata = 8'h00;
            default: acia_rdata = 8'($urandom) | (($urandom_range(3) != 0) ? 8'h02 : 8'h00);
        endcase
    end

    function automatic logic [7:0] c_at(input int i);
        return (i < clog.size()) ? clog[i] : 8'hxx;
    endfunction

    function automatic logic [7:0] d_at(input int i);
        return (i < dlog.size()) ? dlog[i] : 8'hxx;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (!in_ready) chk("push_stall", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin @(negedge clk); n++; end
        chk(nm, busy, 1'b0);
    endtask

    initial begin
        int dn, rb, cn, p0;
        repeat (3) @(negedge clk);
        chk("rst_cs", acia_cs, 0);
        chk("rst_wdata", acia_wdata, 8'h00);
        chk("rst_ready", in_ready, 0);
        chk("rst_level", fifo_level, 0);

        // Initialisation writes with a continuous strobe
        reset = 1'b0; bus_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("init_mrst", c_at(0), 8'h03);
        chk("init_ctrl", c_at(1), 8'h15);
        chk("init_ready", in_ready, 1);
        chk("init_busy", busy, 0);

        // Three bytes in order, each behind one status read
        dn = dlog.size(); rb = rd_cnt; p0 = clkno + 1;
        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
        wait_idle("drain3_idle");
        chk("drain3_b0", d_at(dn), 8'h41);
        chk("drain3_b1", d_at(dn + 1), 8'h42);
        chk("drain3_b2", d_at(dn + 2), 8'h43);
        chk("drain3_reads", rd_cnt - rb, 3);
        chk("latency", ((dclk.size() > dn) ? dclk[dn] : 0) - p0, 4);
        chk("drain3_level", fifo_level, 0);

        // Five busy polls then ready
        dn = dlog.size(); rd_base = rd_cnt; zero_n = 5; rd_mode = 1;
        push_byte(8'h55);
        wait_idle("busy5_idle");
        chk("busy5_reads", rd_cnt - rd_base, 6);
        chk("busy5_byte", d_at(dn), 8'h55);
        chk("busy5_tmo", timeout_err, 0);

        // Stuck TDRE -> timeout, re-init, then retransmit
        dn = dlog.size(); rb = rd_cnt; cn = clog.size(); rd_mode = 2;
        push_byte(8'h66);
        for (int n = 0; n < 300 && !timeout_err; n++) @(negedge clk);
        chk("tmo_flag", timeout_err, 1);
        chk("tmo_reads", rd_cnt - rb, TMO + 1);
        repeat (3) @(negedge clk);
        chk("tmo_remrst", c_at(cn), 8'h03);
        chk("tmo_rectrl", c_at(cn + 1), CW);
        rd_mode = 0;
        wait_idle("tmo_idle");
        chk("tmo_byte", d_at(dn), 8'h66);
        chk("tmo_once", dlog.size() - dn, 1);
        chk("tmo_sticky", timeout_err, 1);

        // Fill to full while TX is blocked, then drain with pushes overlapping pops
        rd_mode = 2;
        for (int i = 0; i < D; i++) push_byte(8'(8'h80 + i));
        chk("full_level", fifo_level, D);
        chk("full_ready", in_ready, 0);
        in_valid = 1'b1; in_data = 8'hEE;
        repeat (3) @(negedge clk);
        chk("full_hold", fifo_level, D);
        rd_mode = 0;
        repeat (25) @(negedge clk);
        in_valid = 1'b0;
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_level", fifo_level, 0);
        chk("midrst_cs", acia_cs, 0);
        chk("midrst_tmo", timeout_err, 0);
        cn = clog.size();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_mrst", c_at(cn), 8'h03);
        chk("midrst_ctrl", c_at(cn + 1), CW);

        // Randomised traffic: sparse strobes, random status, random pushes
        rd_mode = 3;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus_en   = ($urandom_range(1) == 0);
            in_valid = ($urandom_range(4) < 2);
            in_data  = 8'($urandom);
        end
        in_valid = 1'b0; bus_en = 1'b1; rd_mode = 0;
        wait_idle("rand_idle");
        chk("rand_level", fifo_level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: actual=running required=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
